// File: rtl/instruction_prefetch_queue.sv
// Instruction store with a sequential prefetcher and a small queue of
// ready-to-decode instructions. Big-endian byte memory, byte program port,
// redirect/flush with alignment check.
module instruction_prefetch_queue #(
    parameter int                    BUS_WIDTH  = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  ins_ready,
    output logic                  ins_valid,
    output logic [BUS_WIDTH-1:0]  instruction,
    output logic [ADDR_WIDTH-1:0] ins_pc,
    output logic                  misalign_err,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [7:0]            prog_data
);

    localparam int BYTES = BUS_WIDTH / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BYTES);

    logic [7:0]            mem    [0:(1<<ADDR_WIDTH)-1];
    logic [BUS_WIDTH-1:0]  q_data [0:FIFO_DEPTH-1];
    logic [ADDR_WIDTH-1:0] q_pc   [0:FIFO_DEPTH-1];

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] fetch_pc, f_pc;
    logic [BUS_WIDTH-1:0]  f_data, rd_word;
    logic                  f_valid;
    logic                  issue, push, pop;

    // Space check counts the in-flight word but never credits a same-cycle
    // pop, so an issued word always has a slot waiting for it.
    assign issue = fetch_en && !redirect &&
                   ((CNT_W+1)'(count) + (CNT_W+1)'(f_valid) < (CNT_W+1)'(FIFO_DEPTH));
    assign push  = f_valid && !redirect;
    assign pop   = ins_valid && ins_ready && !redirect;

    assign ins_valid   = (count != '0);
    assign instruction = ins_valid ? q_data[rd_ptr] : '0;
    assign ins_pc      = ins_valid ? q_pc[rd_ptr]   : '0;

    // Assemble the big-endian word at fetch_pc; byte addresses wrap.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < BYTES; i++)
            rd_word[BUS_WIDTH-1-8*i -: 8] = mem[fetch_pc + ADDR_WIDTH'(i)];
    end

    // Boot-loader byte writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
    end

    // Queue storage; occupancy is tracked by the control block below.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= f_data;
            q_pc[wr_ptr]   <= f_pc;
        end
    end

    // Fetch stage, queue pointers and redirect handling (redirect wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            f_valid      <= 1'b0;
            f_data       <= '0;
            f_pc         <= '0;
            misalign_err <= 1'b0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else if (redirect) begin
            fetch_pc     <= redirect_pc & ~ALIGN_MASK;
            misalign_err <= |(redirect_pc & ALIGN_MASK);
            f_valid      <= 1'b0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            misalign_err <= 1'b0;
            f_valid      <= issue;
            if (issue) begin
                f_data   <= rd_word;
                f_pc     <= fetch_pc;
                fetch_pc <= fetch_pc + STEP;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Randomized bench for instruction_prefetch_queue against a queue-based
// reference model, plus directed boot, back-pressure, redirect, wrap and
// asynchronous reset scenarios.
module tb_instruction_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0, redirect = 1'b0, ins_ready = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        prog_we = 1'b0;
    logic [15:0] prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic        ins_valid, misalign_err;
    logic [15:0] instruction, ins_pc;

    int n_chk = 0;
    int n_err = 0;

    instruction_prefetch_queue #(
        .BUS_WIDTH(16), .ADDR_WIDTH(16), .FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .ins_ready(ins_ready), .ins_valid(ins_valid),
        .instruction(instruction), .ins_pc(ins_pc), .misalign_err(misalign_err),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    // reference model: byte memory, list of queued words, one in-flight word
    typedef struct { logic [15:0] pc; logic [15:0] data; } ent_t;
    logic [7:0]  mmem [0:65535];
    ent_t        mq [$];
    ent_t        mf;
    bit          mf_v;
    logic [15:0] mfetch;
    bit          mmis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mf_v   = 0;
        mfetch = 16'h0000;
        mmis   = 0;
    endtask

    // one rising edge worth of architectural behaviour
    task automatic model_edge();
        bit   do_pop, do_issue;
        ent_t nf;
        if (rst) begin
            model_reset();
        end else if (redirect) begin
            mq.delete();
            mf_v   = 0;
            mfetch = redirect_pc & 16'hFFFE;
            mmis   = redirect_pc[0];
        end else begin
            mmis     = 0;
            do_pop   = (mq.size() != 0) && ins_ready;
            do_issue = fetch_en && (mq.size() + int'(mf_v) < DEPTH);
            nf.pc    = mfetch;
            nf.data  = {mmem[mfetch], mmem[16'(mfetch + 16'd1)]};
            if (do_pop) void'(mq.pop_front());
            if (mf_v)   mq.push_back(mf);
            mf_v = do_issue;
            if (do_issue) begin
                mf     = nf;
                mfetch = mfetch + 16'd2;
            end
        end
        if (prog_we) mmem[prog_addr] = prog_data;
    endtask

    task automatic check_outputs();
        bit v;
        v = (mq.size() != 0);
        chk("ins_valid", ins_valid, v);
        chk("instruction", instruction, v ? mq[0].data : 16'h0);
        chk("ins_pc", ins_pc, v ? mq[0].pc : 16'h0);
        chk("misalign_err", misalign_err, mmis);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // async reset landing between edges, outputs must clear at once
    task automatic async_reset();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", ins_valid, 1'b0);
        chk("rst_instr", instruction, 16'h0);
        chk("rst_pc", ins_pc, 16'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        model_reset();
        // load program region and the top of memory while held in reset
        for (int a = 0; a < 16'h0200 + 16; a++) begin
            prog_we   = 1'b1;
            prog_addr = (a < 16'h0200) ? 16'(a) : 16'(16'hFFF0 + (a - 16'h0200));
            case (a)
                0: prog_data = 8'h12;
                1: prog_data = 8'h34;
                2: prog_data = 8'h56;
                3: prog_data = 8'h78;
                default: prog_data = 8'($urandom);
            endcase
            step();
        end
        prog_we = 1'b0;
        step();

        // boot: first word on the 2nd edge after release, then one per cycle
        fetch_en = 1'b1;
        ins_ready = 1'b1;
        rst = 1'b0;
        step();
        chk("boot_e1_valid", ins_valid, 1'b0);
        step();
        chk("boot_instr0", instruction, 16'h1234);
        chk("boot_pc0", ins_pc, 16'h0000);
        step();
        chk("boot_instr1", instruction, 16'h5678);
        chk("boot_pc1", ins_pc, 16'h0002);

        // back-pressure: fill, hold head, then drain with no gap or skip
        async_reset();
        ins_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("hold_instr", instruction, 16'h1234);
        ins_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("drain_pc", ins_pc, 16'(2 * i));
            chk("drain_valid", ins_valid, 1'b1);
            step();
        end

        // redirect while full: flushed immediately, new word after two edges
        ins_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        do_redirect(16'h0100);
        chk("redir_flush", ins_valid, 1'b0);
        ins_ready = 1'b1;
        step();
        chk("redir_gap", ins_valid, 1'b0);
        step();
        chk("redir_pc", ins_pc, 16'h0100);

        // misaligned redirect: one-cycle error pulse, aligned restart
        do_redirect(16'h0103);
        chk("mis_pulse", misalign_err, 1'b1);
        step();
        chk("mis_clear", misalign_err, 1'b0);
        step();
        chk("mis_pc", ins_pc, 16'h0102);

        // wrap at top of the address space
        do_redirect(16'hFFFE);
        step();
        step();
        chk("wrap_pc0", ins_pc, 16'hFFFE);
        step();
        chk("wrap_pc1", ins_pc, 16'h0000);

        // mid-stream reset then restart from the reset PC
        for (int i = 0; i < 3; i++) step();
        async_reset();
        step();
        step();
        chk("restart_pc", ins_pc, 16'h0000);

        // randomized traffic, fetch kept inside programmed bytes
        for (int c = 0; c < 4000; c++) begin
            ins_ready = ($urandom % 4) != 0;
            fetch_en  = ($urandom % 8) != 0;
            redirect  = (($urandom % 20) == 0) ||
                        (mfetch >= 16'h01C0 && mfetch < 16'hFFF0);
            redirect_pc = ($urandom % 5 == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                              : 16'($urandom_range(0, 16'h01C0));
            prog_we   = ($urandom % 10) == 0;
            prog_addr = 16'($urandom_range(0, 16'h01FF));
            prog_data = 8'($urandom);
            if (c % 997 == 500) begin
                redirect = 1'b0;
                prog_we  = 1'b0;
                async_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
